pixel_write_queue: RTL and testbench

//  Sits between the bird/hunter draw FSMs and the vga_adapter write port.

---
 rtl/pixel_write_queue.sv | 140 ++++++++++++++
 tb/tb_pixel_write_queue.sv | 233 +++++++++++++++++++++++
 2 files changed

// File: rtl/pixel_write_queue.sv
`default_nettype none
// ============================================================================
// Module      : pixel_write_queue
// Description : Pixel write FIFO between draw FSMs and the VGA adapter, with
//               off-screen filtering and a full-screen clear sweep.
// Revision    : 1.0 - initial release
// ============================================================================
module pixel_write_queue #(
  parameter int DEPTH = 16,
  parameter int X_W   = 8,
  parameter int Y_W   = 7,
  parameter int C_W   = 3,
  parameter int X_MAX = 159,
  parameter int Y_MAX = 119,
  parameter logic [C_W-1:0] BG_COLOUR = '0
) (
  input  logic                       clock,
  input  logic                       resetn,
  input  logic                       in_valid,
  output logic                       in_ready,
  input  logic [X_W-1:0]             in_x,
  input  logic [Y_W-1:0]             in_y,
  input  logic [C_W-1:0]             in_colour,
  input  logic                       clear_req,
  output logic                       clear_busy,
  output logic [X_W-1:0]             vga_x,
  output logic [Y_W-1:0]             vga_y,
  output logic [C_W-1:0]             vga_colour,
  output logic                       vga_plot,
  output logic [$clog2(DEPTH):0]     level,
  output logic [7:0]                 oob_count
);

  localparam int PTR_W = $clog2(DEPTH);
  localparam int LVL_W = PTR_W + 1;
  localparam int ENT_W = X_W + Y_W + C_W;
  localparam logic [LVL_W-1:0] FULL   = LVL_W'(DEPTH);
  localparam logic [X_W-1:0]   X_LAST = X_W'(X_MAX);
  localparam logic [Y_W-1:0]   Y_LAST = Y_W'(Y_MAX);

  typedef enum logic [1:0] {
    RUN        = 2'd0,
    CLEAR_WAIT = 2'd1,
    CLEAR      = 2'd2
  } state_t;

  state_t            state;
  logic [ENT_W-1:0]  mem [DEPTH];
  logic [PTR_W-1:0]  wr_ptr;
  logic [PTR_W-1:0]  rd_ptr;
  logic [X_W-1:0]    sweep_x;
  logic [Y_W-1:0]    sweep_y;

  logic              accept;
  logic              on_screen;
  logic              push;
  logic              pop;
  logic              sweep_go;
  logic              sweep_last;
  logic [ENT_W-1:0]  head;

  assign in_ready   = (state == RUN) && (level < FULL);
  assign clear_busy = (state != RUN);
  assign accept     = in_valid && in_ready;
  assign on_screen  = (in_x <= X_LAST) && (in_y <= Y_LAST);
  assign push       = accept && on_screen;
  assign pop        = (state != CLEAR) && (level != '0);
  // The sweep's first pixel is issued on the same edge that leaves CLEAR_WAIT.
  assign sweep_go   = (state == CLEAR) || ((state == CLEAR_WAIT) && (level == '0));
  assign sweep_last = (sweep_x == X_LAST) && (sweep_y == Y_LAST);
  assign head       = mem[rd_ptr];

  always_ff @(posedge clock) begin
    if (push) begin
      mem[wr_ptr] <= {in_x, in_y, in_colour};
    end
  end

  always_ff @(posedge clock) begin
    if (!resetn) begin
      state      <= RUN;
      wr_ptr     <= '0;
      rd_ptr     <= '0;
      level      <= '0;
      sweep_x    <= '0;
      sweep_y    <= '0;
      oob_count  <= '0;
      vga_x      <= '0;
      vga_y      <= '0;
      vga_colour <= '0;
      vga_plot   <= 1'b0;
    end else begin
      if (push) wr_ptr <= wr_ptr + PTR_W'(1);
      if (pop)  rd_ptr <= rd_ptr + PTR_W'(1);

      case ({push, pop})
        2'b10:   level <= level + LVL_W'(1);
        2'b01:   level <= level - LVL_W'(1);
        default: level <= level;
      endcase

      if (accept && !on_screen && (oob_count != 8'hFF)) begin
        oob_count <= oob_count + 8'd1;
      end

      vga_plot <= 1'b0;
      if (pop) begin
        {vga_x, vga_y, vga_colour} <= head;
        vga_plot                   <= 1'b1;
      end else if (sweep_go) begin
        vga_x      <= sweep_x;
        vga_y      <= sweep_y;
        vga_colour <= BG_COLOUR;
        vga_plot   <= 1'b1;
        // Counters wrap back to origin after the last pixel, ready for the next clear.
        if (sweep_x == X_LAST) begin
          sweep_x <= '0;
          sweep_y <= (sweep_y == Y_LAST) ? '0 : sweep_y + Y_W'(1);
        end else begin
          sweep_x <= sweep_x + X_W'(1);
        end
      end

      case (state)
        RUN: begin
          if (clear_req) state <= CLEAR_WAIT;
        end
        CLEAR_WAIT: begin
          if (level == '0) state <= sweep_last ? RUN : CLEAR;
        end
        CLEAR: begin
          if (sweep_last) state <= RUN;
        end
        default: state <= RUN;
      endcase
    end
  end

endmodule
`default_nettype wire

// File: tb/tb_pixel_write_queue.sv
`default_nettype none
// ============================================================================
// Module      : tb_pixel_write_queue
// Description : Directed vector bench for pixel_write_queue.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_pixel_write_queue;

  logic       clock = 1'b0;
  logic       resetn;
  logic       in_valid;
  logic       in_ready;
  logic [7:0] in_x;
  logic [6:0] in_y;
  logic [2:0] in_colour;
  logic       clear_req;
  logic       clear_busy;
  logic [7:0] vga_x;
  logic [6:0] vga_y;
  logic [2:0] vga_colour;
  logic       vga_plot;
  logic [4:0] level;
  logic [7:0] oob_count;

  int checks   = 0;
  int failures = 0;

  pixel_write_queue dut (
    .clock      (clock),
    .resetn     (resetn),
    .in_valid   (in_valid),
    .in_ready   (in_ready),
    .in_x       (in_x),
    .in_y       (in_y),
    .in_colour  (in_colour),
    .clear_req  (clear_req),
    .clear_busy (clear_busy),
    .vga_x      (vga_x),
    .vga_y      (vga_y),
    .vga_colour (vga_colour),
    .vga_plot   (vga_plot),
    .level      (level),
    .oob_count  (oob_count)
  );

  always #5 clock = ~clock;

  typedef struct {
    logic       valid;
    logic [7:0] x;
    logic [6:0] y;
    logic [2:0] c;
    logic       rdy;
    logic       plot;
    logic [7:0] ex;
    logic [6:0] ey;
    logic [2:0] ec;
    logic [4:0] lvl;
    logic [7:0] oob;
  } vec_t;

  vec_t vecs [11];

  function automatic vec_t mk(logic v, int x, int y, int c, logic rdy, logic plot,
                              int ex, int ey, int ec, int lvl, int oob);
    vec_t r;
    r.valid = v;       r.x  = 8'(x);  r.y  = 7'(y);  r.c  = 3'(c);
    r.rdy   = rdy;     r.plot = plot;
    r.ex    = 8'(ex);  r.ey = 7'(ey); r.ec = 3'(ec);
    r.lvl   = 5'(lvl); r.oob = 8'(oob);
    return r;
  endfunction

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
    checks++;
    if (act !== req) begin
      failures++;
      $display("FAIL %s actual=%0d required=%0d", name, act, req);
    end
  endtask

  // Advance one clock; outputs are then sampled 1 time unit after the edge.
  task automatic step();
    @(posedge clock);
    #1;
  endtask

  initial begin
    int n, errs, sent, recv, first, last, bad_ready, plots, cyc;
    logic acc, found;
    logic [7:0] ex, fx, lx;
    logic [6:0] ey, fy, ly;
    logic [2:0] ec;

    vecs[0]  = mk(1, 10, 20, 7,   1, 0,   0,   0, 0, 0, 0);
    vecs[1]  = mk(0,  0,  0, 0,   1, 0,   0,   0, 0, 1, 0);
    vecs[2]  = mk(0,  0,  0, 0,   1, 1,  10,  20, 7, 0, 0);
    vecs[3]  = mk(1, 255, 127, 1, 1, 0,  10,  20, 7, 0, 0);
    vecs[4]  = mk(1, 160,  5, 2,  1, 0,  10,  20, 7, 0, 1);
    vecs[5]  = mk(1,  5, 120, 3,  1, 0,  10,  20, 7, 0, 2);
    vecs[6]  = mk(1,  0,  0, 5,   1, 0,  10,  20, 7, 0, 3);
    vecs[7]  = mk(1, 159, 119, 6, 1, 0,  10,  20, 7, 1, 3);
    vecs[8]  = mk(0,  0,  0, 0,   1, 1,   0,   0, 5, 1, 3);
    vecs[9]  = mk(0,  0,  0, 0,   1, 1, 159, 119, 6, 0, 3);
    vecs[10] = mk(0,  0,  0, 0,   1, 0, 159, 119, 6, 0, 3);

    resetn = 1'b0; in_valid = 1'b0; in_x = '0; in_y = '0; in_colour = '0; clear_req = 1'b0;
    step(); step();
    check("reset_plot",  32'(vga_plot),   0);
    check("reset_x",     32'(vga_x),      0);
    check("reset_level", 32'(level),      0);
    check("reset_oob",   32'(oob_count),  0);
    check("reset_busy",  32'(clear_busy), 0);
    check("reset_ready", 32'(in_ready),   1);
    resetn = 1'b1;

    // Single pixel latency, off-screen filter and push/pop overlap.
    for (int i = 0; i < 11; i++) begin
      in_valid = vecs[i].valid; in_x = vecs[i].x; in_y = vecs[i].y; in_colour = vecs[i].c;
      check($sformatf("vec%0d_ready", i), 32'(in_ready),   32'(vecs[i].rdy));
      check($sformatf("vec%0d_plot", i),  32'(vga_plot),   32'(vecs[i].plot));
      check($sformatf("vec%0d_x", i),     32'(vga_x),      32'(vecs[i].ex));
      check($sformatf("vec%0d_y", i),     32'(vga_y),      32'(vecs[i].ey));
      check($sformatf("vec%0d_c", i),     32'(vga_colour), 32'(vecs[i].ec));
      check($sformatf("vec%0d_level", i), 32'(level),      32'(vecs[i].lvl));
      check($sformatf("vec%0d_oob", i),   32'(oob_count),  32'(vecs[i].oob));
      step();
    end
    in_valid = 1'b0;

    // 20 back-to-back pixels with in_valid held high.
    sent = 0; recv = 0; errs = 0; first = -1; last = -1; bad_ready = 0;
    for (int c = 0; c < 100 && recv < 20; c++) begin
      in_valid  = (sent < 20);
      in_x      = 8'(50 + sent);
      in_y      = 7'(10 + sent);
      in_colour = 3'(sent);
      if (level == 5'd16 && in_ready) bad_ready++;
      if (vga_plot) begin
        if (vga_x !== 8'(50 + recv) || vga_y !== 7'(10 + recv) || vga_colour !== 3'(recv)) errs++;
        if (recv == 0) first = c;
        last = c;
        recv++;
      end
      acc = in_valid && in_ready;
      step();
      if (acc) sent++;
    end
    in_valid = 1'b0;
    check("burst_received",  32'(recv),        20);
    check("burst_order",     32'(errs),        0);
    check("burst_contig",    32'(last - first), 19);
    check("burst_ready_full", 32'(bad_ready),  0);
    check("burst_level",     32'(level),       0);

    // oob_count saturation.
    plots = 0;
    for (int i = 0; i < 300; i++) begin
      in_valid = 1'b1; in_x = 8'd200; in_y = 7'd3; in_colour = 3'd0;
      if (i == 100) check("oob_mid", 32'(oob_count), 103);
      if (vga_plot) plots++;
      step();
    end
    in_valid = 1'b0;
    if (vga_plot) plots++;
    check("oob_sat",   32'(oob_count), 255);
    check("oob_plots", 32'(plots),     0);

    // Five pixels, then clear; a second clear_req during the sweep is ignored.
    n = 0; errs = 0; cyc = 0; fx = '1; fy = '1; lx = '0; ly = '0;
    while (n < 19205 && cyc < 19600) begin
      in_valid  = (cyc < 5);
      in_x      = 8'(30 + cyc);
      in_y      = 7'(40 + cyc);
      in_colour = 3'(cyc + 1);
      clear_req = (cyc == 5) || (n == 105);
      if (cyc == 6) begin
        check("clear_ready_drop", 32'(in_ready),   0);
        check("clear_busy_rise",  32'(clear_busy), 1);
      end
      if (vga_plot) begin
        if (n < 5) begin
          ex = 8'(30 + n); ey = 7'(40 + n); ec = 3'(n + 1);
        end else begin
          ex = 8'((n - 5) % 160); ey = 7'((n - 5) / 160); ec = 3'd0;
        end
        if (vga_x !== ex || vga_y !== ey || vga_colour !== ec) errs++;
        if (n == 5)     begin fx = vga_x; fy = vga_y; end
        if (n == 19204) begin lx = vga_x; ly = vga_y; end
        n++;
      end
      step();
      cyc++;
    end
    in_valid = 1'b0; clear_req = 1'b0;
    check("clear_plot_count", 32'(n),    19205);
    check("clear_seq_errs",   32'(errs), 0);
    check("clear_first_x",    32'(fx),   0);
    check("clear_first_y",    32'(fy),   0);
    check("clear_last_x",     32'(lx),   159);
    check("clear_last_y",     32'(ly),   119);
    check("clear_end_plot",   32'(vga_plot),   0);
    check("clear_end_busy",   32'(clear_busy), 0);
    check("clear_end_ready",  32'(in_ready),   1);

    // Reset in the middle of a sweep.
    clear_req = 1'b1;
    step();
    clear_req = 1'b0;
    found = 1'b0;
    for (int c = 0; c < 20000 && !found; c++) begin
      if (vga_plot && vga_x == 8'd40 && vga_y == 7'd60) found = 1'b1;
      else step();
    end
    check("midsweep_reached", 32'(found), 1);
    resetn = 1'b0;
    step();
    check("midsweep_plot",  32'(vga_plot),   0);
    check("midsweep_busy",  32'(clear_busy), 0);
    check("midsweep_level", 32'(level),      0);
    check("midsweep_ready", 32'(in_ready),   1);
    check("midsweep_oob",   32'(oob_count),  0);
    resetn = 1'b1;
    step();
    check("post_reset_plot", 32'(vga_plot),   0);
    check("post_reset_busy", 32'(clear_busy), 0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
`default_nettype wire
